// File: rtl/imm_encoder.sv
// Multi-cycle encoder for the ARM data-processing rotated 8-bit immediate.
// Finds the smallest rotate_imm such that VALUE == ROR(immed_8, 2*rotate_imm).
module imm_encoder #(
    parameter int unsigned ROTS_PER_CYCLE = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] VALUE,
    output logic        BUSY,
    output logic        DONE,
    output logic        VALID,
    output logic [11:0] IMM12,
    output logic        C_ROT
);

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  rot_q, rot_d;
    logic [31:0] v_q, v_d;
    logic        valid_q, valid_d;
    logic [11:0] imm12_q, imm12_d;
    logic        c_rot_q, c_rot_d;

    logic        hit;
    logic [3:0]  hit_rot;
    logic [7:0]  hit_imm;
    logic [3:0]  cand_rot;
    logic [31:0] cand;

    function automatic logic [31:0] rol2(input logic [31:0] v, input logic [3:0] r);
        logic [63:0] dbl;
        dbl = {v, v} << {r, 1'b0};
        return dbl[63:32];
    endfunction

    // Priority search over this cycle's group; the lowest hitting rotation wins.
    always_comb begin
        hit      = 1'b0;
        hit_rot  = 4'd0;
        hit_imm  = 8'd0;
        cand_rot = 4'd0;
        cand     = 32'd0;
        for (int i = 0; i < ROTS_PER_CYCLE; i++) begin
            cand_rot = rot_q[3:0] + 4'(i);
            cand     = rol2(v_q, cand_rot);
            if (!hit && cand[31:8] == 24'd0) begin
                hit     = 1'b1;
                hit_rot = cand_rot;
                hit_imm = cand[7:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        v_d     = v_q;
        valid_d = valid_q;
        imm12_d = imm12_q;
        c_rot_d = c_rot_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    v_d     = VALUE;
                    rot_d   = 5'd0;
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (hit) begin
                    imm12_d = {hit_rot, hit_imm};
                    valid_d = 1'b1;
                    c_rot_d = (hit_rot != 4'd0) & v_q[31];
                    state_d = StDone;
                end else if (rot_q + 5'(ROTS_PER_CYCLE) == 5'd16) begin
                    imm12_d = 12'd0;
                    valid_d = 1'b0;
                    c_rot_d = 1'b0;
                    state_d = StDone;
                end else begin
                    rot_d = rot_q + 5'(ROTS_PER_CYCLE);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            rot_q   <= 5'd0;
            v_q     <= 32'd0;
            valid_q <= 1'b0;
            imm12_q <= 12'd0;
            c_rot_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            v_q     <= v_d;
            valid_q <= valid_d;
            imm12_q <= imm12_d;
            c_rot_q <= c_rot_d;
        end
    end

    assign BUSY  = (state_q != StIdle);
    assign DONE  = (state_q == StDone);
    assign VALID = valid_q;
    assign IMM12 = imm12_q;
    assign C_ROT = c_rot_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder with one rotation per cycle.
module tb_imm_encoder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [31:0] VALUE = 32'd0;
    logic        BUSY, DONE, VALID, C_ROT;
    logic [11:0] IMM12;

    int checks = 0;
    int errors = 0;

    imm_encoder #(.ROTS_PER_CYCLE(1)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .VALUE (VALUE),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .VALID (VALID),
        .IMM12 (IMM12),
        .C_ROT (C_ROT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Accept val at E0, count edges until DONE, then check result and return to idle.
    task automatic run(input string tag, input logic [31:0] val, input int exp_lat,
                       input logic exp_valid, input logic [11:0] exp_imm,
                       input logic exp_crot);
        int n;
        @(negedge CLK);
        START = 1'b1;
        VALUE = val;
        @(posedge CLK);
        #1;
        START = 1'b0;
        VALUE = ~val;
        n = 0;
        while (!DONE && n < 40) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " valid"}, 32'(VALID), 32'(exp_valid));
        chk({tag, " imm12"}, 32'(IMM12), 32'(exp_imm));
        chk({tag, " c_rot"}, 32'(C_ROT), 32'(exp_crot));
        chk({tag, " busy_in_done"}, 32'(BUSY), 32'd1);
        @(posedge CLK);
        #1;
        chk({tag, " done_pulse"}, 32'(DONE), 32'd0);
        chk({tag, " idle"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        int n;
        logic saw_done;
        #2;
        chk("rst busy", 32'(BUSY), 32'd0);
        chk("rst done", 32'(DONE), 32'd0);
        chk("rst valid", 32'(VALID), 32'd0);
        chk("rst imm12", 32'(IMM12), 32'd0);
        chk("rst c_rot", 32'(C_ROT), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        run("t1_ff", 32'h0000_00FF, 1, 1'b1, 12'h0FF, 1'b0);
        run("t2_ff000000", 32'hFF00_0000, 5, 1'b1, 12'h4FF, 1'b1);
        run("t2_f000000f", 32'hF000_000F, 3, 1'b1, 12'h2FF, 1'b1);
        run("t3_104", 32'h0000_0104, 16, 1'b1, 12'hF41, 1'b0);
        run("t4_102", 32'h0000_0102, 16, 1'b0, 12'h000, 1'b0);
        run("zero", 32'h0000_0000, 1, 1'b1, 12'h000, 1'b0);
        run("min_rot_3f0", 32'h0000_03F0, 15, 1'b1, 12'hE3F, 1'b0);

        // START held high with VALUE changing every cycle during the search
        @(negedge CLK);
        START = 1'b1;
        VALUE = 32'hFF00_0000;
        @(posedge CLK);
        #1;
        n = 0;
        while (!DONE && n < 40) begin
            VALUE = 32'h0000_03FC + 32'(n);
            @(posedge CLK);
            #1;
            n++;
        end
        chk("t5 latency", 32'(n), 32'd5);
        chk("t5 imm12", 32'(IMM12), 32'h4FF);
        chk("t5 c_rot", 32'(C_ROT), 32'd1);
        VALUE = 32'h0000_00FF;
        @(posedge CLK);
        #1;
        chk("t5 idle_after_done", 32'(BUSY), 32'd0);
        @(posedge CLK);
        #1;
        START = 1'b0;
        chk("t5 reaccept", 32'(BUSY), 32'd1);
        chk("t5 hold_imm12", 32'(IMM12), 32'h4FF);
        chk("t5 hold_valid", 32'(VALID), 32'd1);
        @(posedge CLK);
        #1;
        chk("t5 second_done", 32'(DONE), 32'd1);
        chk("t5 second_imm12", 32'(IMM12), 32'h0FF);
        chk("t5 second_c_rot", 32'(C_ROT), 32'd0);
        @(posedge CLK);
        #1;

        // Reset in the middle of a search on 32'hFF000000
        @(negedge CLK);
        START = 1'b1;
        VALUE = 32'hFF00_0000;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("t6 busy_before_rst", 32'(BUSY), 32'd1);
        RESET = 1'b1;
        #1;
        chk("t6 rst busy", 32'(BUSY), 32'd0);
        chk("t6 rst done", 32'(DONE), 32'd0);
        chk("t6 rst valid", 32'(VALID), 32'd0);
        chk("t6 rst imm12", 32'(IMM12), 32'd0);
        chk("t6 rst c_rot", 32'(C_ROT), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge CLK);
            #1;
            if (DONE) saw_done = 1'b1;
        end
        chk("t6 no_done", 32'(saw_done), 32'd0);
        run("t6_after", 32'hFF00_0000, 5, 1'b1, 12'h4FF, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
